// File: rtl/cflow_mr_if.sv
// CFLog write port between cflow_mr and the log memory / TCB drain logic.
interface cflow_mr_if;
  logic        log_wen;
  logic [15:0] log_ptr;
  logic [15:0] log_data;
  logic        flush;
  logic        flush_ack;

  modport master (output log_wen, log_ptr, log_data, flush, input flush_ack);
  modport slave  (input log_wen, log_ptr, log_data, flush, output flush_ack);
endinterface

// File: rtl/cflow_mr.sv
// Multi-region control-flow attestation: captures taken transfers inside the
// executable regions, compresses repeats and writes (src,dest) words to the CFLog.
module cflow_mr #(
  parameter int          NUM_ER     = 2,
  parameter logic [15:0] LOG_SIZE   = 16'h0100,
  parameter int          CTR_W      = 16,
  parameter logic [15:0] TCB_MIN    = 16'hdffe,
  parameter logic [15:0] RESET_ADDR = 16'he000,
  parameter logic [15:0] PMEM_MIN   = 16'he03e
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           pc,
  input  logic [15:0]           pc_nxt,
  input  logic                  branch_detect,
  input  logic [16*NUM_ER-1:0]  er_min,
  input  logic [16*NUM_ER-1:0]  er_max,
  input  logic                  data_wr,
  input  logic [15:0]           data_addr,
  input  logic                  dma_en,
  input  logic [15:0]           dma_addr,
  input  logic                  spec_hit,
  input  logic [15:0]           spec_addr,
  input  logic [15:0]           spec_id,
  cflow_mr_if.master            log_bus,
  output logic                  reset_req,
  output logic [NUM_ER-1:0]     er_done,
  output logic                  boot,
  output logic                  overrun
);

  typedef enum logic [2:0] {IDLE, WR_CTR, WR_SRC, WR_DST, WR_SPEC, FLUSH} state_t;

  localparam logic [13:0] REP_MAX = (CTR_W >= 14) ? 14'h3FFF : 14'((32'd1 << CTR_W) - 1);

  state_t      state, state_nxt;
  logic [15:0] ptr, prev_pc;
  logic [31:0] fifo_mem [2];
  logic        fifo_wr, fifo_rd;
  logic [1:0]  fifo_cnt;
  logic        fifo_pop, push, push_ok;
  logic [31:0] head, cur_pair, last_pair;
  logic        last_valid;
  logic [13:0] rep_ctr, ctr_val;
  logic        spec_pend;
  logic [15:0] spec_addr_q, spec_id_q;
  logic        boot_done;
  logic        take, compress;
  logic [15:0] room, need;
  logic        wen;
  logic [15:0] wptr, wdata;
  logic        unused_pc_nxt;

  assign unused_pc_nxt = ^pc_nxt;

  function automatic logic in_region(input logic [15:0] a);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_ER; i++)
      if (a >= er_min[16*i +: 16] && a <= er_max[16*i +: 16]) r = 1'b1;
    return r;
  endfunction

  assign push    = branch_detect & in_region(pc);
  assign push_ok = push & ((fifo_cnt != 2'd2) | fifo_pop);
  assign head    = fifo_mem[fifo_rd];

  // Payload storage needs no reset; validity is tracked by fifo_cnt.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[fifo_wr] <= {prev_pc, pc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr  <= 1'b0;
      fifo_rd  <= 1'b0;
      fifo_cnt <= 2'd0;
      overrun  <= 1'b0;
      prev_pc  <= 16'h0000;
    end else begin
      prev_pc <= pc;
      if (push_ok) fifo_wr <= ~fifo_wr;
      if (fifo_pop) fifo_rd <= ~fifo_rd;
      case ({push_ok, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push && !push_ok) overrun <= 1'b1;
    end
  end

  assign room = (ptr >= LOG_SIZE) ? 16'd0 : LOG_SIZE - ptr;
  assign need = (rep_ctr != 14'd0) ? 16'd3 : 16'd2;

  // The room check leaves the pair in the FIFO so it is retried after the drain.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    take      = 1'b0;
    compress  = 1'b0;
    wen       = 1'b0;
    wptr      = ptr;
    wdata     = 16'h0000;
    case (state)
      IDLE: begin
        if (spec_hit || spec_pend) begin
          state_nxt = WR_SPEC;
        end else if (fifo_cnt != 2'd0) begin
          if (last_valid && head == last_pair && rep_ctr < REP_MAX) begin
            fifo_pop = 1'b1;
            compress = 1'b1;
          end else if (need > room) begin
            state_nxt = FLUSH;
          end else begin
            fifo_pop  = 1'b1;
            take      = 1'b1;
            state_nxt = (rep_ctr != 14'd0) ? WR_CTR : WR_SRC;
          end
        end
      end
      WR_CTR: begin
        wen       = 1'b1;
        wdata     = {2'b11, ctr_val};
        state_nxt = WR_SRC;
      end
      WR_SRC: begin
        wen       = 1'b1;
        wdata     = cur_pair[31:16];
        state_nxt = WR_DST;
      end
      WR_DST: begin
        wen       = 1'b1;
        wdata     = cur_pair[15:0];
        state_nxt = IDLE;
      end
      WR_SPEC: begin
        wen       = 1'b1;
        wptr      = spec_addr_q;
        wdata     = spec_id_q;
        state_nxt = IDLE;
      end
      FLUSH: begin
        if (log_bus.flush_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign log_bus.log_wen  = wen;
  assign log_bus.log_ptr  = wptr;
  assign log_bus.log_data = wdata;
  assign log_bus.flush    = (state == FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 16'h0000;
      cur_pair    <= 32'h0;
      last_pair   <= 32'h0;
      last_valid  <= 1'b0;
      rep_ctr     <= 14'd0;
      ctr_val     <= 14'd0;
      spec_pend   <= 1'b0;
      spec_addr_q <= 16'h0000;
      spec_id_q   <= 16'h0000;
    end else begin
      state <= state_nxt;
      case (state)
        WR_CTR, WR_SRC, WR_DST: ptr <= ptr + 16'd1;
        WR_SPEC:                ptr <= spec_addr_q + 16'd1;
        FLUSH:                  if (log_bus.flush_ack) ptr <= 16'h0000;
        default:                ptr <= ptr;
      endcase
      if (compress) rep_ctr <= rep_ctr + 14'd1;
      if (take) begin
        cur_pair   <= head;
        last_pair  <= head;
        last_valid <= 1'b1;
        ctr_val    <= rep_ctr;
        rep_ctr    <= 14'd0;
      end
      if (state == WR_SPEC) begin
        last_valid <= 1'b0;
        rep_ctr    <= 14'd0;
      end
      // A hit during a burst stays pending until the FSM returns to IDLE.
      if (spec_hit) begin
        spec_pend   <= 1'b1;
        spec_addr_q <= spec_addr;
        spec_id_q   <= spec_id;
      end else if (state == WR_SPEC) begin
        spec_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reset_req <= 1'b0;
      boot_done <= 1'b0;
    end else begin
      reset_req <= (data_wr && in_region(data_addr)) || (dma_en && in_region(dma_addr));
      if (pc == TCB_MIN) boot_done <= 1'b1;
      else if (pc == RESET_ADDR) boot_done <= 1'b0;
    end
  end

  assign boot = (pc == PMEM_MIN);

  always_comb begin
    er_done = '0;
    for (int i = 0; i < NUM_ER; i++)
      er_done[i] = (pc == er_max[16*i +: 16]) && boot_done;
  end

endmodule

// File: tb/tb_cflow_mr.sv
// Directed self-checking bench for cflow_mr (2 regions, 16-word log).
module tb_cflow_mr;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc = 16'h0000, pc_nxt = 16'h0000;
  logic        branch_detect = 1'b0;
  logic [31:0] er_min = {16'hE200, 16'hE100};
  logic [31:0] er_max = {16'hE2FF, 16'hE1FF};
  logic        data_wr = 1'b0, dma_en = 1'b0, spec_hit = 1'b0;
  logic [15:0] data_addr = 16'h0000, dma_addr = 16'h0000;
  logic [15:0] spec_addr = 16'h0000, spec_id = 16'h0000;
  logic        reset_req, boot, overrun;
  logic [1:0]  er_done;

  int checks = 0;
  int passed = 0;
  int wr_count = 0;
  logic [15:0] log_mem [16];

  cflow_mr_if bus();

  cflow_mr #(.NUM_ER(2), .LOG_SIZE(16'h0010)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_nxt(pc_nxt),
    .branch_detect(branch_detect), .er_min(er_min), .er_max(er_max),
    .data_wr(data_wr), .data_addr(data_addr), .dma_en(dma_en), .dma_addr(dma_addr),
    .spec_hit(spec_hit), .spec_addr(spec_addr), .spec_id(spec_id),
    .log_bus(bus), .reset_req(reset_req), .er_done(er_done), .boot(boot),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Log memory model fed from the write port.
  always @(negedge clk) begin
    if (rst_n && bus.log_wen) begin
      log_mem[bus.log_ptr[3:0]] = bus.log_data;
      wr_count++;
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic do_branch(input logic [15:0] a, input logic [15:0] b);
    pc = a; branch_detect = 1'b0;
    step();
    pc = b; branch_detect = 1'b1;
    step();
    branch_detect = 1'b0;
  endtask

  task automatic do_spec(input logic [15:0] addr, input logic [15:0] id);
    spec_hit = 1'b1; spec_addr = addr; spec_id = id;
    step();
    spec_hit = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush_ack = 1'b0;
    step(2);
    checks++; if ({bus.log_wen, bus.flush, reset_req, overrun} !== 4'b0000) $display("[TB] FAIL reset_flags got %b expected 0000", {bus.log_wen, bus.flush, reset_req, overrun}); else passed++;
    checks++; if (bus.log_ptr !== 16'h0000) $display("[TB] FAIL reset_ptr got %h expected 0000", bus.log_ptr); else passed++;
    checks++; if (er_done !== 2'b00) $display("[TB] FAIL reset_er_done got %b expected 00", er_done); else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    do_branch(16'hE120, 16'hE150);
    pc = 16'hE151;
    checks++; if (bus.log_wen !== 1'b0) $display("[TB] FAIL basic_t1_wen got %b expected 0", bus.log_wen); else passed++;
    step();
    checks++; if ({bus.log_wen, bus.log_ptr, bus.log_data} !== {1'b1, 16'h0000, 16'hE120}) $display("[TB] FAIL basic_src got %b/%h/%h expected 1/0000/e120", bus.log_wen, bus.log_ptr, bus.log_data); else passed++;
    step();
    checks++; if ({bus.log_wen, bus.log_ptr, bus.log_data} !== {1'b1, 16'h0001, 16'hE150}) $display("[TB] FAIL basic_dst got %b/%h/%h expected 1/0001/e150", bus.log_wen, bus.log_ptr, bus.log_data); else passed++;
    step();
    checks++; if ({bus.log_wen, bus.log_ptr} !== {1'b0, 16'h0002}) $display("[TB] FAIL basic_idle got %b/%h expected 0/0002", bus.log_wen, bus.log_ptr); else passed++;
  endtask

  task automatic test_compress();
    logic [15:0] exp [5];
    int base;
    exp = '{16'hE120, 16'hE150, 16'hC004, 16'hE160, 16'hE100};
    do_reset();
    base = wr_count;
    for (int k = 0; k < 5; k++) begin
      do_branch(16'hE120, 16'hE150);
      step(4);
    end
    do_branch(16'hE160, 16'hE100);
    step(6);
    for (int k = 0; k < 5; k++) begin
      checks++; if (log_mem[k] !== exp[k]) $display("[TB] FAIL compress_word%0d got %h expected %h", k, log_mem[k], exp[k]); else passed++;
    end
    checks++; if (wr_count - base !== 5) $display("[TB] FAIL compress_count got %0d expected 5", wr_count - base); else passed++;
    checks++; if (bus.log_ptr !== 16'h0005) $display("[TB] FAIL compress_ptr got %h expected 0005", bus.log_ptr); else passed++;
  endtask

  task automatic test_spec();
    do_spec(16'h0009, 16'h0AAA);
    step(2);
    checks++; if (bus.log_ptr !== 16'h000A) $display("[TB] FAIL spec_ptr10 got %h expected 000a", bus.log_ptr); else passed++;
    spec_hit = 1'b1; spec_addr = 16'h0004; spec_id = 16'h0007;
    step();
    spec_hit = 1'b0;
    checks++; if ({bus.log_wen, bus.log_ptr, bus.log_data} !== {1'b1, 16'h0004, 16'h0007}) $display("[TB] FAIL spec_write got %b/%h/%h expected 1/0004/0007", bus.log_wen, bus.log_ptr, bus.log_data); else passed++;
    step();
    checks++; if (bus.log_ptr !== 16'h0005) $display("[TB] FAIL spec_ptr_after got %h expected 0005", bus.log_ptr); else passed++;
    do_branch(16'hE160, 16'hE100);
    step(5);
    checks++; if ({log_mem[5], log_mem[6]} !== {16'hE160, 16'hE100}) $display("[TB] FAIL spec_pair got %h %h expected e160 e100", log_mem[5], log_mem[6]); else passed++;
    // Spec hit arriving mid-burst
    do_branch(16'hE130, 16'hE140);
    step();
    do_spec(16'h000C, 16'h0055);
    step(6);
    checks++; if ({log_mem[7], log_mem[8]} !== {16'hE130, 16'hE140}) $display("[TB] FAIL spec_mid_pair got %h %h expected e130 e140", log_mem[7], log_mem[8]); else passed++;
    checks++; if ({log_mem[12], bus.log_ptr} !== {16'h0055, 16'h000D}) $display("[TB] FAIL spec_mid_word got %h ptr %h expected 0055 ptr 000d", log_mem[12], bus.log_ptr); else passed++;
  endtask

  task automatic test_flush();
    do_spec(16'h000D, 16'h0D0D);
    step(2);
    do_branch(16'hE170, 16'hE180);
    step(5);
    checks++; if ({log_mem[14], log_mem[15]} !== {16'hE170, 16'hE180}) $display("[TB] FAIL flush_exact_fit got %h %h expected e170 e180", log_mem[14], log_mem[15]); else passed++;
    checks++; if (bus.flush !== 1'b0) $display("[TB] FAIL flush_early got %b expected 0", bus.flush); else passed++;
    do_branch(16'hE190, 16'hE1A0);
    checks++; if (bus.flush !== 1'b0) $display("[TB] FAIL flush_check_cycle got %b expected 0", bus.flush); else passed++;
    step();
    checks++; if ({bus.flush, bus.log_wen} !== 2'b10) $display("[TB] FAIL flush_assert got %b expected 10", {bus.flush, bus.log_wen}); else passed++;
    do_branch(16'hE1B0, 16'hE1C0);
    step();
    checks++; if (overrun !== 1'b0) $display("[TB] FAIL overrun_full got %b expected 0", overrun); else passed++;
    do_branch(16'hE1D0, 16'hE1E0);
    step();
    checks++; if ({overrun, bus.flush} !== 2'b11) $display("[TB] FAIL overrun_set got %b expected 11", {overrun, bus.flush}); else passed++;
    bus.flush_ack = 1'b1;
    step();
    bus.flush_ack = 1'b0;
    checks++; if ({bus.flush, bus.log_ptr} !== {1'b0, 16'h0000}) $display("[TB] FAIL flush_release got %b/%h expected 0/0000", bus.flush, bus.log_ptr); else passed++;
    step(8);
    checks++; if ({log_mem[0], log_mem[1], log_mem[2], log_mem[3]} !== {16'hE190, 16'hE1A0, 16'hE1B0, 16'hE1C0}) $display("[TB] FAIL flush_drain got %h %h %h %h expected e190 e1a0 e1b0 e1c0", log_mem[0], log_mem[1], log_mem[2], log_mem[3]); else passed++;
    checks++; if (bus.log_ptr !== 16'h0004) $display("[TB] FAIL flush_ptr got %h expected 0004", bus.log_ptr); else passed++;
  endtask

  task automatic test_boundary();
    logic [15:0] addrs [5];
    logic        is_dma [5];
    logic        exp [5];
    addrs  = '{16'hE180, 16'h0200, 16'hE0FF, 16'hE1FF, 16'hE250};
    is_dma = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) begin
      dma_en = is_dma[k]; dma_addr = addrs[k];
      data_wr = ~is_dma[k]; data_addr = addrs[k];
      step();
      dma_en = 1'b0; data_wr = 1'b0;
      checks++; if (reset_req !== exp[k]) $display("[TB] FAIL boundary_%h got %b expected %b", addrs[k], reset_req, exp[k]); else passed++;
      step();
      checks++; if (reset_req !== 1'b0) $display("[TB] FAIL boundary_pulse_%h got %b expected 0", addrs[k], reset_req); else passed++;
    end
  endtask

  task automatic test_boot();
    pc = 16'hE03E;
    #1;
    checks++; if (boot !== 1'b1) $display("[TB] FAIL boot_pmem got %b expected 1", boot); else passed++;
    pc = 16'hE2FF;
    #1;
    checks++; if (er_done !== 2'b00) $display("[TB] FAIL er_done_preboot got %b expected 00", er_done); else passed++;
    pc = 16'hDFFE;
    step();
    pc = 16'hE2FF;
    #1;
    checks++; if ({er_done, boot} !== 3'b100) $display("[TB] FAIL er_done_1 got %b expected 100", {er_done, boot}); else passed++;
    pc = 16'hE1FF;
    #1;
    checks++; if (er_done !== 2'b01) $display("[TB] FAIL er_done_0 got %b expected 01", er_done); else passed++;
    step();
    pc = 16'hE000;
    step();
    pc = 16'hE2FF;
    #1;
    checks++; if (er_done !== 2'b00) $display("[TB] FAIL er_done_cleared got %b expected 00", er_done); else passed++;
  endtask

  task automatic test_reset_abort();
    int base;
    do_branch(16'hE120, 16'hE150);
    step();
    checks++; if (bus.log_wen !== 1'b1) $display("[TB] FAIL abort_burst got %b expected 1", bus.log_wen); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.log_wen, bus.log_ptr, overrun} !== {1'b0, 16'h0000, 1'b0}) $display("[TB] FAIL abort_async got %b/%h/%b expected 0/0000/0", bus.log_wen, bus.log_ptr, overrun); else passed++;
    step();
    rst_n = 1'b1;
    base = wr_count;
    step(5);
    checks++; if (wr_count - base !== 0) $display("[TB] FAIL abort_no_resume got %0d writes expected 0", wr_count - base); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_compress();
    test_spec();
    test_flush();
    test_boundary();
    test_boot();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
